// File: rtl/ru_pkg.sv
// Shared types and RV32I load/store width encodings for the RAM requester.
package ru_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MERGE,
        S_WR,
        S_DONE,
        S_ERR
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/ru_byte_lane.sv
// Little-endian lane steering: sub-word load extract/extend and sub-word store merge.
module ru_byte_lane
    import ru_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] base_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_val = {24'h0, byte_sel};
            F3_HU:   load_val = {16'h0, half_sel};
            default: load_val = rdata;
        endcase
    end

    always_comb begin
        merged = base_word;
        if (funct3 == F3_B) begin
            case (addr_lo)
                2'd0:    merged[7:0]   = store_data[7:0];
                2'd1:    merged[15:8]  = store_data[7:0];
                2'd2:    merged[23:16] = store_data[7:0];
                default: merged[31:24] = store_data[7:0];
            endcase
        end else if (funct3 == F3_H) begin
            if (addr_lo[1]) merged[31:16] = store_data[15:0];
            else            merged[15:0]  = store_data[15:0];
        end
    end

endmodule

// File: rtl/ru_mem_requester.sv
// Core-side load/store initiator for the word RAM: stalls the core, does RMW for sb/sh,
// and aborts misaligned, out-of-range, illegal or busy-timed-out accesses with err.
module ru_mem_requester
    import ru_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = 32,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    input  logic        ram_busy
);

    localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

    mem_state_t    state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   sdata_q, sdata_d;
    logic [31:0]   load_q, load_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    lo_q, lo_d;
    logic          is_load_q, is_load_d;

    logic          req, bad_f3, misaligned, out_of_range;
    logic [31:0]   load_val, merged;

    // RD extracts straight from the RAM data; MERGE patches the word captured into wdata_q.
    ru_byte_lane u_lane (
        .funct3     (f3_q),
        .addr_lo    (lo_q),
        .rdata      (ram_rdata),
        .base_word  (wdata_q),
        .store_data (sdata_q),
        .load_val   (load_val),
        .merged     (merged)
    );

    assign req = req_load | req_store;

    always_comb begin
        if (req_store)
            bad_f3 = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        else
            bad_f3 = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                       funct3 == F3_BU || funct3 == F3_HU);
        misaligned   = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                       (funct3 == F3_W && addr[1:0] != 2'b00);
        out_of_range = {2'b00, addr[31:2]} >= 32'(MEM_WORDS);
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sdata_d   = sdata_q;
        load_d    = load_q;
        f3_d      = f3_q;
        lo_d      = lo_q;
        is_load_d = is_load_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d    = {addr[31:2], 2'b00};
                    f3_d      = funct3;
                    lo_d      = addr[1:0];
                    is_load_d = req_load;
                    sdata_d   = store_data;
                    if (req_store) wdata_d = store_data;
                    if ((req_load && req_store) || bad_f3 || misaligned || out_of_range)
                        state_d = S_ERR;
                    else if (req_store && funct3 == F3_W)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                if (ram_busy) begin
                    tmo_d = tmo_q + CW'(1);
                    if (tmo_d == CW'(BUSY_TIMEOUT)) state_d = S_ERR;
                end else if (is_load_q) begin
                    load_d  = load_val;
                    state_d = S_DONE;
                end else begin
                    wdata_d = ram_rdata;
                    state_d = S_MERGE;
                end
            end
            S_MERGE: begin
                wdata_d = merged;
                state_d = S_WR;
            end
            S_WR: begin
                if (ram_busy) begin
                    tmo_d = tmo_q + CW'(1);
                    if (tmo_d == CW'(BUSY_TIMEOUT)) state_d = S_ERR;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sdata_q   <= '0;
            load_q    <= '0;
            f3_q      <= '0;
            lo_q      <= '0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sdata_q   <= sdata_d;
            load_q    <= load_d;
            f3_q      <= f3_d;
            lo_q      <= lo_d;
            is_load_q <= is_load_d;
        end
    end

    // The write strobe follows ram_busy within WR so a busy RAM never sees a write.
    assign ram_we    = (state_q == S_WR) && !ram_busy;
    assign done      = (state_q == S_DONE) || (state_q == S_ERR);
    assign err       = (state_q == S_ERR);
    assign stall     = (state_q == S_RD) || (state_q == S_MERGE) || (state_q == S_WR) ||
                       ((state_q == S_IDLE) && req);
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign load_data = load_q;

endmodule

// File: tb/tb_ru_mem_requester.sv
// Directed-vector bench for ru_mem_requester with a 32-word behavioural RAM.
module tb_ru_mem_requester;
    import ru_pkg::*;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        req_load = 1'b0, req_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0, store_data = '0;
    logic [31:0] load_data, ram_addr, ram_wdata, ram_rdata;
    logic        stall, done, err, ram_we;
    logic        ram_busy = 1'b0;

    logic [31:0] mem [32];

    int vec_cnt = 0;
    int miscmp  = 0;
    int r_stalls, r_wes;
    logic r_err, r_done;

    ru_mem_requester #(.MEM_WORDS(32), .BUSY_TIMEOUT(16)) dut (
        .clk(clk), .nRst(nRst), .req_load(req_load), .req_store(req_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .load_data(load_data),
        .stall(stall), .done(done), .err(err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata), .ram_busy(ram_busy)
    );

    always #5 clk = ~clk;

    always_comb ram_rdata = (ram_addr[31:7] == '0) ? mem[ram_addr[6:2]] : 32'h0;

    always @(posedge clk)
        if (ram_we && !ram_busy && ram_addr[31:7] == '0) mem[ram_addr[6:2]] <= ram_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request and holds it until done; ram_busy is high for cycles 1..busy_n.
    task automatic run(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int busy_n);
        @(negedge clk);
        req_load = ld; req_store = st; funct3 = f3; addr = a; store_data = d;
        r_stalls = 0; r_wes = 0; r_err = 1'b0; r_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ram_busy = (i >= 1 && i <= busy_n);
            #1;
            if (done) begin
                r_done = 1'b1;
                r_err  = err;
                break;
            end
            if (stall)  r_stalls++;
            if (ram_we) r_wes++;
            @(negedge clk);
        end
        check("done_seen", {31'b0, r_done}, 32'd1);
        req_load = 1'b0; req_store = 1'b0; ram_busy = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0] = 32'h8899_AABB;
        mem[2] = 32'hCAFE_F00D;

        repeat (2) @(negedge clk);
        check("rst_load_data", load_data, 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_ctl", {28'h0, stall, done, err, ram_we}, 32'h0);
        nRst = 1'b1;

        run(1'b1, 1'b0, F3_B, 32'h1, 32'h0, 0);
        check("lb_val", load_data, 32'hFFFF_FFAA);
        check("lb_stalls", r_stalls, 32'd2);
        check("lb_err", {31'b0, r_err}, 32'd0);

        run(1'b1, 1'b0, F3_HU, 32'h2, 32'h0, 0);
        check("lhu_val", load_data, 32'h0000_8899);
        run(1'b1, 1'b0, F3_H, 32'h2, 32'h0, 0);
        check("lh_val", load_data, 32'hFFFF_8899);
        run(1'b1, 1'b0, F3_BU, 32'h0, 32'h0, 0);
        check("lbu_val", load_data, 32'h0000_00BB);
        run(1'b1, 1'b0, F3_W, 32'h0, 32'h0, 0);
        check("lw_val", load_data, 32'h8899_AABB);

        run(1'b0, 1'b1, F3_B, 32'h3, 32'h11, 0);
        check("sb_we_cycles", r_wes, 32'd1);
        check("sb_stalls", r_stalls, 32'd4);
        check("sb_mem0", mem[0], 32'h1199_AABB);
        check("sb_ld_held", load_data, 32'h8899_AABB);

        run(1'b0, 1'b1, F3_W, 32'h4, 32'hDEAD_BEEF, 3);
        check("sw_busy_err", {31'b0, r_err}, 32'd0);
        check("sw_busy_we", r_wes, 32'd1);
        check("sw_busy_stalls", r_stalls, 32'd5);
        check("sw_ram_addr", ram_addr, 32'h4);
        check("sw_mem1", mem[1], 32'hDEAD_BEEF);

        run(1'b0, 1'b1, F3_H, 32'h6, 32'h1234_ABCD, 0);
        check("sh_mem1", mem[1], 32'hABCD_BEEF);
        run(1'b1, 1'b0, F3_W, 32'h4, 32'h0, 0);
        check("lw1_val", load_data, 32'hABCD_BEEF);

        run(1'b1, 1'b0, F3_W, 32'h6, 32'h0, 0);
        check("lw_mis_err", {31'b0, r_err}, 32'd1);
        check("lw_mis_stalls", r_stalls, 32'd1);
        check("lw_mis_we", r_wes, 32'd0);
        check("lw_mis_ld", load_data, 32'hABCD_BEEF);

        run(1'b0, 1'b1, F3_W, 32'h80, 32'h5555_5555, 0);
        check("sw_oor_err", {31'b0, r_err}, 32'd1);
        check("sw_oor_we", r_wes, 32'd0);

        run(1'b1, 1'b0, F3_HU, 32'h1, 32'h0, 0);
        check("lhu_mis_err", {31'b0, r_err}, 32'd1);
        run(1'b0, 1'b1, F3_BU, 32'h0, 32'h0, 0);
        check("sbu_ill_err", {31'b0, r_err}, 32'd1);
        run(1'b0, 1'b1, 3'b011, 32'h0, 32'h0, 0);
        check("f3_ill_err", {31'b0, r_err}, 32'd1);
        run(1'b1, 1'b1, F3_W, 32'h0, 32'h0, 0);
        check("both_req_err", {31'b0, r_err}, 32'd1);
        check("mem0_intact", mem[0], 32'h1199_AABB);

        run(1'b1, 1'b0, F3_W, 32'h0, 32'h0, 100);
        check("tmo_err", {31'b0, r_err}, 32'd1);
        check("tmo_stalls", r_stalls, 32'd17);
        check("tmo_ld", load_data, 32'hABCD_BEEF);

        run(1'b1, 1'b0, F3_B, 32'h7, 32'h0, 0);
        check("lb3_val", load_data, 32'hFFFF_FFAB);

        // sb to word2, reset asserted while the FSM sits in MERGE
        @(negedge clk);
        req_store = 1'b1; funct3 = F3_B; addr = 32'h8; store_data = 32'h55;
        repeat (2) @(negedge clk);
        req_store = 1'b0; nRst = 1'b0;
        #1;
        check("rst_mid_ctl", {28'h0, stall, done, err, ram_we}, 32'h0);
        check("rst_mid_addr", ram_addr, 32'h0);
        check("rst_mid_wdata", ram_wdata, 32'h0);
        check("rst_mid_ld", load_data, 32'h0);
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_mem2", mem[2], 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
